// File: rtl/lp_compute_unit.sv
// lp_compute_unit: handshaked 2-operand ALU with per-transaction power mode; LP MUL uses an
// iterative shift-add multiplier. Define CU_AUTO_SLEEP_EN to enable idle auto-sleep.
module lp_compute_unit #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned IDLE_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       op,
    input  logic [1:0]       pmode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       fls,
    output logic             busy,
    output logic             sleep_o
);
    localparam int unsigned SW  = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || IDLE_TIMEOUT < 1) begin : g_param_check
        $error("lp_compute_unit: WIDTH must be a power of 2 >= 4, IDLE_TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {StIdle, StExec, StDone, StSleep} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     op1_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [SW-1:0]        cnt_q;
    logic [WIDTH-1:0]     result_q, hi_q;
    logic [3:0]           fls_q;

    logic                 accept, lp_mul, exec_last;
    logic                 auto_trip; // idle timeout expires this cycle
    logic                 auto_q;    // asleep because of idle timeout rather than pmode

    assign in_ready  = (state_q == StIdle) && !pmode[1] && !rst;
    assign accept    = in_valid && in_ready;
    assign lp_mul    = (pmode == 2'd1) && (op == 3'd2);
    assign exec_last = (cnt_q == SW'(WIDTH - 1));

    // Single-cycle datapath, evaluated on the live operands at the accept edge.
    logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
    logic [2*WIDTH-1:0] mul_w;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   alu_lo, alu_hi;
    logic               alu_v, alu_c;
    logic [3:0]         alu_fls;

    always_comb begin
        shamt  = op2[SW-1:0];
        add_w  = {1'b0, op1} + {1'b0, op2};
        sub_w  = {1'b0, op1} - {1'b0, op2};
        shl_w  = {1'b0, op1} << shamt;
        shr_w  = {op1, 1'b0} >> shamt;
        mul_w  = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
        alu_lo = '0;
        alu_hi = '0;
        alu_v  = 1'b0;
        alu_c  = 1'b0;
        case (op)
            3'd0: begin
                alu_lo = add_w[WIDTH-1:0];
                alu_c  = add_w[WIDTH];
                alu_v  = (op1[MSB] == op2[MSB]) && (add_w[MSB] != op1[MSB]);
            end
            3'd1: begin
                alu_lo = sub_w[WIDTH-1:0];
                alu_c  = sub_w[WIDTH];
                alu_v  = (op1[MSB] != op2[MSB]) && (sub_w[MSB] != op1[MSB]);
            end
            3'd2: begin
                alu_lo = mul_w[WIDTH-1:0];
                alu_hi = mul_w[2*WIDTH-1:WIDTH];
                alu_c  = |mul_w[2*WIDTH-1:WIDTH];
                alu_v  = |mul_w[2*WIDTH-1:WIDTH];
            end
            3'd3: alu_lo = op1 & op2;
            3'd4: alu_lo = op1 | op2;
            3'd5: alu_lo = op1 ^ op2;
            3'd6: begin
                alu_lo = shl_w[WIDTH-1:0];
                alu_c  = shl_w[WIDTH];
            end
            3'd7: begin
                alu_lo = shr_w[WIDTH:1];
                alu_c  = shr_w[0];
            end
            default: ;
        endcase
        alu_fls = {alu_v, alu_c, alu_lo[MSB], (alu_lo == '0) && (alu_hi == '0)};
    end

    // Shift-add step: conditionally add multiplicand to the high half, then shift right.
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     acc;
    logic [2*WIDTH-1:0] step;

    assign addend = prod_q[0] ? op1_q : '0;
    assign acc    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign step   = {acc, prod_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pmode[1])       state_d = StSleep;
                else if (accept)    state_d = lp_mul ? StExec : StDone;
                else if (auto_trip) state_d = StSleep;
            end
            StExec:  if (exec_last) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            StSleep: if (auto_q ? in_valid : !pmode[1]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op1_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            fls_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op1_q  <= op1;
                prod_q <= {{WIDTH{1'b0}}, op2};
                cnt_q  <= '0;
            end else if (state_q == StExec) begin
                prod_q <= step;
                cnt_q  <= cnt_q + 1'b1;
            end
            if (accept && !lp_mul) begin
                result_q <= alu_lo;
                hi_q     <= alu_hi;
                fls_q    <= alu_fls;
            end else if (state_q == StExec && exec_last) begin
                result_q <= step[WIDTH-1:0];
                hi_q     <= step[2*WIDTH-1:WIDTH];
                fls_q    <= {|step[2*WIDTH-1:WIDTH], |step[2*WIDTH-1:WIDTH], step[MSB],
                             step == '0};
            end
        end
    end

`ifdef CU_AUTO_SLEEP_EN
    localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);

    logic [1:0]    pmode_q;
    logic [TW-1:0] idle_cnt_q;
    logic          idle_lp;
    logic          auto_d;

    assign idle_lp   = (state_q == StIdle) && (pmode_q == 2'd1) && !in_valid && !pmode[1];
    assign auto_trip = idle_lp && (idle_cnt_q == TW'(IDLE_TIMEOUT - 1));
    assign auto_d    = (state_d == StSleep) && (auto_trip || auto_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            pmode_q    <= '0;
            idle_cnt_q <= '0;
            auto_q     <= 1'b0;
        end else begin
            if (accept) pmode_q <= pmode;
            idle_cnt_q <= (idle_lp && !auto_trip) ? idle_cnt_q + 1'b1 : '0;
            auto_q     <= auto_d;
        end
    end
`else
    assign auto_trip = 1'b0;
    assign auto_q    = 1'b0;
`endif

    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StExec) || (state_q == StDone);
    assign sleep_o   = (state_q == StSleep);
    assign result    = result_q;
    assign result_hi = hi_q;
    assign fls       = fls_q;

endmodule

// File: tb/tb_lp_compute_unit.sv
// Self-checking bench for lp_compute_unit: directed vector table plus hand sequences for
// DONE stall, reset abort, pmode sleep and (with CU_AUTO_SLEEP_EN) idle auto-sleep.
module tb_lp_compute_unit;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1, op2;
    logic [2:0]   op;
    logic [1:0]   pmode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result, result_hi;
    logic [3:0]   fls;
    logic         busy;
    logic         sleep_o;

    int n_checks = 0;
    int n_errors = 0;

    lp_compute_unit #(.WIDTH(W), .IDLE_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .op(op), .pmode(pmode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .fls(fls),
        .busy(busy), .sleep_o(sleep_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   pm;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   fl;
        int           lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a command, wait for accept, scramble inputs, then count cycles to out_valid.
    task automatic run_cmd(input logic [2:0] c_op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] pm, output int lat);
        int guard = 0;
        op = c_op; op1 = a; op2 = b; pmode = pm;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_cmd", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op1 = ~a; op2 = ~b; op = ~c_op; pmode = 2'd0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;

        //            op    a         b         pm    res       hi        VCNZ     lat
        vecs[0]  = '{3'd0, 16'h0002, 16'h0004, 2'd0, 16'h0006, 16'h0000, 4'b0000, 1};
        vecs[1]  = '{3'd2, 16'h0002, 16'h0005, 2'd0, 16'h000A, 16'h0000, 4'b0000, 1};
        vecs[2]  = '{3'd2, 16'h0002, 16'h0005, 2'd1, 16'h000A, 16'h0000, 4'b0000, 17};
        vecs[3]  = '{3'd2, 16'hFFFF, 16'hFFFF, 2'd0, 16'h0001, 16'hFFFE, 4'b1100, 1};
        vecs[4]  = '{3'd0, 16'h7FFF, 16'h0001, 2'd0, 16'h8000, 16'h0000, 4'b1010, 1};
        vecs[5]  = '{3'd1, 16'h0000, 16'h0001, 2'd0, 16'hFFFF, 16'h0000, 4'b0110, 1};
        vecs[6]  = '{3'd6, 16'h8001, 16'h0001, 2'd0, 16'h0002, 16'h0000, 4'b0100, 1};
        vecs[7]  = '{3'd5, 16'h00FF, 16'h00FF, 2'd0, 16'h0000, 16'h0000, 4'b0001, 1};
        vecs[8]  = '{3'd3, 16'hF0F0, 16'h3C3C, 2'd0, 16'h3030, 16'h0000, 4'b0000, 1};
        vecs[9]  = '{3'd4, 16'h8000, 16'h0001, 2'd0, 16'h8001, 16'h0000, 4'b0010, 1};
        vecs[10] = '{3'd7, 16'h8003, 16'h0002, 2'd0, 16'h2000, 16'h0000, 4'b0100, 1};
        vecs[11] = '{3'd6, 16'h1234, 16'h0010, 2'd0, 16'h1234, 16'h0000, 4'b0000, 1};
        vecs[12] = '{3'd0, 16'h0003, 16'h0004, 2'd1, 16'h0007, 16'h0000, 4'b0000, 1};
        vecs[13] = '{3'd2, 16'hFFFF, 16'h0003, 2'd1, 16'hFFFD, 16'h0002, 4'b1110, 17};
        vecs[14] = '{3'd1, 16'h0005, 16'h0005, 2'd1, 16'h0000, 16'h0000, 4'b0001, 1};
        vecs[15] = '{3'd0, 16'hFFFF, 16'h0001, 2'd0, 16'h0000, 16'h0000, 4'b0101, 1};
        vecs[16] = '{3'd2, 16'h0000, 16'h1234, 2'd1, 16'h0000, 16'h0000, 4'b0001, 17};
        vecs[17] = '{3'd7, 16'h8000, 16'h000F, 2'd0, 16'h0001, 16'h0000, 4'b0000, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; op = '0; pmode = 2'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sleep", 32'(sleep_o), 32'd0);
        chk("rst_outputs", {result, result_hi}, 32'd0);
        chk("rst_fls", 32'(fls), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table; out_ready held high, including before DONE
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pm, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
            chk($sformatf("vec%0d_result_hi", i), 32'(result_hi), 32'(vecs[i].hi));
            chk($sformatf("vec%0d_fls", i), 32'(fls), 32'(vecs[i].fl));
            @(negedge clk);
            chk($sformatf("vec%0d_handshake", i), 32'(out_valid), 32'd0);
        end

        // DONE stall with out_ready low
        out_ready = 1'b0;
        run_cmd(3'd0, 16'h0001, 16'h0001, 2'd0, lat);
        chk("stall_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_result", i), 32'(result), 32'h0002);
            chk($sformatf("stall%0d_fls", i), 32'(fls), 32'd0);
            chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        chk("stall_release_in_ready", 32'(in_ready), 32'd1);
        run_cmd(3'd0, 16'd10, 16'd20, 2'd0, lat);
        chk("after_stall_latency", 32'(lat), 32'd1);
        chk("after_stall_result", 32'(result), 32'd30);
        @(negedge clk);

        // Reset five cycles into an LP MUL
        op = 3'd2; op1 = 16'd2; op2 = 16'd5; pmode = 2'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_outputs", {result, result_hi}, 32'd0);
        chk("abort_fls", 32'(fls), 32'd0);
        chk("abort_sleep", 32'(sleep_o), 32'd0);
        rst = 1'b0;
        pmode = 2'd0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_out_valid", 32'(seen), 32'd0);

        // pmode-driven sleep
        pmode = 2'd2;
        in_valid = 1'b1;
        @(negedge clk);
        chk("psleep_in_ready", 32'(in_ready), 32'd0);
        chk("psleep_sleep", 32'(sleep_o), 32'd1);
        @(negedge clk);
        chk("psleep_no_accept", 32'(busy), 32'd0);
        in_valid = 1'b0;
        pmode = 2'd0;
        @(negedge clk);
        chk("pwake_sleep", 32'(sleep_o), 32'd0);
        chk("pwake_in_ready", 32'(in_ready), 32'd1);

        // Idle behaviour after an LP transaction
        run_cmd(3'd0, 16'd1, 16'd2, 2'd1, lat);
        chk("lp_add_result", 32'(result), 32'd3);
        @(negedge clk);
        pmode = 2'd1;
        repeat (7) @(negedge clk);
        chk("idle7_sleep", 32'(sleep_o), 32'd0);
        @(negedge clk);
`ifdef CU_AUTO_SLEEP_EN
        chk("auto_sleep", 32'(sleep_o), 32'd1);
        chk("auto_sleep_in_ready", 32'(in_ready), 32'd0);
        op = 3'd0; op1 = 16'd3; op2 = 16'd4;
        in_valid = 1'b1;
        @(negedge clk);
        chk("auto_wake_sleep", 32'(sleep_o), 32'd0);
        chk("auto_wake_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("auto_wake_valid", 32'(out_valid), 32'd1);
        chk("auto_wake_result", 32'(result), 32'd7);
`else
        chk("no_auto_sleep", 32'(sleep_o), 32'd0);
        chk("no_auto_in_ready", 32'(in_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("no_auto_sleep_late", 32'(sleep_o), 32'd0);
`endif
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lp_compute_unit.md
# lp_compute_unit

- Parametrised, handshaked successor to the single-width compute unit in the low-power datapath.
- Executes one 2-operand arithmetic/logic operation per transaction with valid/ready flow control and per-transaction power mode.
- In low-power mode, an area/power-lean iterative shift-add multiplier replaces the single-cycle multiplier; optional automatic sleep on idle.

## Interface
- WIDTH, 16, operand/result width (≥4, power of 2)
- IDLE_TIMEOUT, 8, idle cycles before auto-sleep (only with CU_AUTO_SLEEP_EN)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  command valid
- in_ready  out  1  unit can accept command
- op1, op2  in  WIDTH  operands
- op  in  3  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR
- pmode  in  2  0 NORMAL, 1 LP, 2/3 SLEEP
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  result (MUL: low half)
- result_hi  out  WIDTH  MUL high half, else 0
- fls  out  4  {V, C, N, Z}
- busy  out  1  state is EXEC or DONE
- sleep_o  out  1  unit asleep

## Operation
- FSM: IDLE, EXEC, DONE, SLEEP.
- IDLE:
  - in_ready=1 unless pmode is SLEEP; if pmode is SLEEP, go SLEEP.
  - Accept = in_valid & in_ready: latch op1, op2, op, pmode. Operand registers load only on accept.
- Accept with LP+MUL → EXEC. Any other accept → compute and go DONE.
- EXEC: one shift-add step per cycle, WIDTH steps, then DONE.
- DONE: out_valid=1; result/result_hi/fls stable until out_ready=1, then IDLE. in_ready=0 in EXEC and DONE.
- SLEEP: in_ready=0, sleep_o=1. Leave to IDLE when pmode≠SLEEP.
- pmode changes after accept are ignored for that transaction. SLEEP requested mid-transaction takes effect after the DONE handshake.
- Arithmetic, all mod 2^WIDTH:
  - ADD: C = carry out; V = signed overflow.
  - SUB: op1−op2; C = borrow (op1<op2 unsigned); V = signed overflow.
  - MUL: unsigned 2·WIDTH product in {result_hi,result}; C = V = (result_hi≠0).
  - AND/OR/XOR: C = V = 0.
  - SHL/SHR: logical, amount = op2[log2(WIDTH)-1:0]; C = last bit shifted out (0 for amount 0); V = 0.
  - N = result[WIDTH-1].
  - Z = (result==0), and for MUL also requires result_hi==0.
- Outputs hold the last completed values outside DONE.

## Timing
- Reset (rst=1 at a posedge):
  - Next cycle state IDLE; out_valid, in_ready, busy, sleep_o = 0; result, result_hi, fls = 0.
  - in_ready rises the first cycle rst is low (if pmode≠SLEEP).
- Latency, accept edge to out_valid high:
  - 1 cycle for all ops in NORMAL and non-MUL in LP.
  - WIDTH+1 cycles for LP MUL.
- Throughput: at most one transaction per 2 cycles (accept, DONE handshake).
- Reset mid-EXEC or mid-DONE aborts. No out_valid follows; the result is lost.
- in_valid may drop without accept; no state change.
- out_ready high before DONE has no effect.

## Configuration
- CU_AUTO_SLEEP_EN defined:
  - In IDLE with the last accepted pmode=LP, a counter tracks consecutive cycles with in_valid=0.
  - On reaching IDLE_TIMEOUT, enter SLEEP (sleep_o=1, in_ready=0).
  - in_valid=1 while auto-asleep wakes the unit: IDLE with in_ready=1 on the next cycle. The command is accepted then, not during sleep.
  - Counter clears on in_valid or accept.
- Undefined: no counter; SLEEP entered only via pmode.

## Test plan
- NORMAL ADD 2+4 → out_valid 1 cycle after accept, result=6, result_hi=0, fls=0000; then MUL 2×5 → result=10, 1 cycle.
- LP MUL 2×5 → busy high, out_valid exactly 17 cycles after accept, result=10; NORMAL MUL 0xFFFF×0xFFFF → result=0x0001, result_hi=0xFFFE, V=C=1.
- ADD 0x7FFF+0x0001 → 0x8000, V=1 N=1 C=0 Z=0; SUB 0−1 → 0xFFFF, C=1 N=1; SHL 0x8001 by 1 → 0x0002, C=1; XOR 0x00FF^0x00FF → 0, Z=1.
- out_ready=0 for 5 cycles in DONE → out_valid, result, fls stable and in_ready=0 throughout; out_ready=1 → IDLE and next command accepted.
- rst asserted 5 cycles into LP MUL → out_valid never rises, all outputs 0; in_ready=1 the cycle after rst drops.
- CU_AUTO_SLEEP_EN, LP, in_valid low 8 cycles → sleep_o=1, in_ready=0; in_valid=1 → in_ready=1 next cycle, ADD 3+4 returns 7. pmode=SLEEP in IDLE → in_ready=0, sleep_o=1.
